instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//   Fetch stage of the multicycle CPU. Holds the PC and drives the word address of the
//   synchronous-read instruction memory. Captures the returned word into the instruction
//   register (IR) and presents it to the decode/control stage over a valid/ready handshake.
//   Handles branch/jump redirects and counts accepted instructions.
// PARAMETERS
//   RESET_PC  32'h0000_0000  PC after reset; bits [1:0] are forced to 0
//   IM_AW     10             instruction-memory word-address width (im_addr = pc[IM_AW+1:2])
// PORTS
//   clk           in   1   clock; all state updates on posedge
//   rst           in   1   synchronous reset, active-high
//   im_addr       out  IM_AW  word address to IM; always equals pc[IM_AW+1:2]
//   im_dout       in   32  IM read data; reflects im_addr sampled at the previous posedge
//   ir_valid      out  1   IR holds an instruction not yet accepted
//   ir_ready      in   1   decode accepts the IR this cycle
//   ir            out  32  instruction register
//   ir_pc         out  32  byte address of the instruction in ir
//   pc            out  32  current fetch PC (byte address)
//   redirect      in   1   load redirect_pc as the new PC (branch/jump taken)
//   redirect_pc   in   32  redirect target (byte address)
//   misalign_err  out  1   sticky flag: a redirect target had bits [1:0] != 0
//   fetch_count   out  32  number of accepted instructions (valid & ready)
// BEHAVIOUR
//   Reset: pc=RESET_PC&~3, ir=0, ir_pc=0, ir_valid=0, misalign_err=0, fetch_count=0,
//     state=F_ADDR. rst has priority over every other input, including mid-handshake.
//   FSM, one transition per posedge:
//     F_ADDR: im_addr=pc is presented; IM samples it at this edge -> F_WAIT.
//     F_WAIT: im_dout is valid; ir<=im_dout, ir_pc<=pc, ir_valid<=1 -> HOLD.
//     HOLD:   ir_valid=1; ir and ir_pc are stable. On ir_valid&ir_ready: pc<=pc+4,
//             ir_valid<=0, fetch_count++ -> F_ADDR. Otherwise stay in HOLD.
//   Latency: ir_valid rises 2 cycles after entry to F_ADDR (first valid is the 2nd posedge
//     after rst release). Throughput with ir_ready=1: one instruction per 3 cycles.
//   Redirect (any state): pc<=redirect_pc&~3, ir_valid<=0 -> F_ADDR. It overrides the
//     normal transition. In F_WAIT the returned word is discarded and never presented.
//   Redirect together with a handshake in HOLD: the instruction counts as accepted
//     (fetch_count++), and the PC takes redirect_pc, not pc+4.
//   Misaligned redirect_pc: bits [1:0] are cleared and misalign_err is set to 1. It stays
//     set until rst.
//   Arithmetic: pc+4 is modulo 2^32. im_addr aliases every 4 KB (pc[31:IM_AW+2] ignored).
//     ir_pc reports the full 32-bit PC. fetch_count wraps modulo 2^32.
//   ir_ready is ignored while ir_valid=0. ir and ir_pc hold their last value while not in HOLD.
// TESTING  (IM model: ROM[0]=32'h014A4822, ROM[1]=32'h21290001, ROM[2]=32'h08000001,
//           ROM[1023]=32'hDEADBEEF)
//   1 rst high 2 cycles, then low, ir_ready=1 -> ir_valid high at 2nd edge with
//     ir=014A4822, ir_pc=0. It is high again 3 cycles later with ir=21290001, ir_pc=4.
//     fetch_count=2 after the second accept.
//   2 ir_ready=0 for 10 cycles in HOLD -> ir_valid stays 1; ir, ir_pc, pc and fetch_count
//     remain unchanged; im_addr remains constant.
//   3 redirect=1, redirect_pc=8 during F_WAIT -> ir_valid stays 0 and the stale word is
//     never presented. The next valid has ir=08000001, ir_pc=8.
//   4 in HOLD, ir_ready=1 and redirect=1 with redirect_pc=4 in the same cycle ->
//     fetch_count+1; the next ir_pc=4.
//   5 redirect_pc=32'h6 -> pc=4, misalign_err=1. It stays 1 through later fetches, then
//     clears on rst.
//   6 redirect_pc=32'hFFC -> ir=DEADBEEF. After accept: pc=32'h1000, im_addr=0,
//     ir=014A4822, ir_pc=32'h1000. Then assert rst while in HOLD -> ir_valid=0 next cycle,
//     and the fetch restarts at 0.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Fetch stage of the multicycle CPU: PC register, synchronous-read IM addressing,
// instruction register with a valid/ready handshake, redirects and an accept counter.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IM_AW    = 10
) (
    input  logic             clk,
    input  logic             rst,
    output logic [IM_AW-1:0] im_addr,
    input  logic [31:0]      im_dout,
    output logic             ir_valid,
    input  logic             ir_ready,
    output logic [31:0]      ir,
    output logic [31:0]      ir_pc,
    output logic [31:0]      pc,
    input  logic             redirect,
    input  logic [31:0]      redirect_pc,
    output logic             misalign_err,
    output logic [31:0]      fetch_count
);

    localparam logic [1:0] F_ADDR = 2'd0;
    localparam logic [1:0] F_WAIT = 2'd1;
    localparam logic [1:0] HOLD   = 2'd2;

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    logic [1:0] state;
    logic       accept;

    // The IM registers this address itself, so the word arrives one edge later.
    assign im_addr = pc[IM_AW+1:2];
    assign accept  = ir_valid & ir_ready;

    // NOTE: all state here is updated with non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc           <= RESET_PC_ALIGNED;
            ir           <= 32'h0;
            ir_pc        <= 32'h0;
            ir_valid     <= 1'b0;
            misalign_err <= 1'b0;
            fetch_count  <= 32'h0;
            state        <= F_ADDR;
        end else begin
            // An accepted instruction counts even when a redirect lands in the same cycle.
            if (accept) begin
                fetch_count <= fetch_count + 32'd1;
            end

            if (redirect) begin
                pc       <= {redirect_pc[31:2], 2'b00};
                ir_valid <= 1'b0;
                state    <= F_ADDR;
                if (redirect_pc[1:0] != 2'b00) begin
                    misalign_err <= 1'b1;
                end
            end else begin
                case (state)
                    F_ADDR: begin
                        state <= F_WAIT;
                    end
                    F_WAIT: begin
                        ir       <= im_dout;
                        ir_pc    <= pc;
                        ir_valid <= 1'b1;
                        state    <= HOLD;
                    end
                    HOLD: begin
                        if (accept) begin
                            pc       <= pc + 32'd4;
                            ir_valid <= 1'b0;
                            state    <= F_ADDR;
                        end
                    end
                    default: begin
                        ir_valid <= 1'b0;
                        state    <= F_ADDR;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios followed by random
// ready/redirect/reset traffic, all compared against a transaction-level fetch model.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  im_addr;
    logic [31:0] im_dout;
    logic        ir_valid;
    logic        ir_ready;
    logic [31:0] ir;
    logic [31:0] ir_pc;
    logic [31:0] pc;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        misalign_err;
    logic [31:0] fetch_count;

    int tests    = 0;
    int failures = 0;

    logic [31:0] rom [0:1023];

    // Reference state: what the fetch stage should look like from outside.
    logic [31:0] m_pc, m_ir, m_ir_pc, m_cnt;
    logic        m_valid, m_err;
    int          m_age;   // cycles spent fetching the current PC

    instr_fetch_unit dut (
        .clk(clk), .rst(rst), .im_addr(im_addr), .im_dout(im_dout),
        .ir_valid(ir_valid), .ir_ready(ir_ready), .ir(ir), .ir_pc(ir_pc), .pc(pc),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .misalign_err(misalign_err), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) im_dout <= rom[im_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        logic acc;
        if (rst) begin
            m_pc = 32'h0; m_ir = 32'h0; m_ir_pc = 32'h0; m_valid = 1'b0;
            m_err = 1'b0; m_cnt = 32'h0; m_age = 0;
        end else begin
            acc = m_valid && ir_ready;
            if (acc) m_cnt = m_cnt + 1;
            if (redirect) begin
                m_pc = redirect_pc & ~32'h3;
                if (redirect_pc[1:0] != 2'b00) m_err = 1'b1;
                m_valid = 1'b0;
                m_age = 0;
            end else if (acc) begin
                m_pc = m_pc + 4;
                m_valid = 1'b0;
                m_age = 0;
            end else if (!m_valid) begin
                m_age++;
                if (m_age == 2) begin
                    m_valid = 1'b1;
                    m_ir    = rom[m_pc[11:2]];
                    m_ir_pc = m_pc;
                end
            end
        end
    endtask

    task automatic compare_all();
        check("ir_valid", {31'b0, ir_valid}, {31'b0, m_valid});
        check("pc", pc, m_pc);
        check("im_addr", {22'b0, im_addr}, {22'b0, m_pc[11:2]});
        check("ir", ir, m_ir);
        check("ir_pc", ir_pc, m_ir_pc);
        check("fetch_count", fetch_count, m_cnt);
        check("misalign_err", {31'b0, misalign_err}, {31'b0, m_err});
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = $urandom;
        rom[0]    = 32'h014A4822;
        rom[1]    = 32'h21290001;
        rom[2]    = 32'h08000001;
        rom[1023] = 32'hDEADBEEF;

        // 1: reset, first two fetches with decode always ready
        rst = 1'b1; ir_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        tick(); tick();
        check("rst_ir_valid", {31'b0, ir_valid}, 32'h0);
        check("rst_pc", pc, 32'h0);
        check("rst_count", fetch_count, 32'h0);
        rst = 1'b0; ir_ready = 1'b1;
        tick();
        check("t1_not_yet_valid", {31'b0, ir_valid}, 32'h0);
        tick();
        check("t1_valid0", {31'b0, ir_valid}, 32'h1);
        check("t1_ir0", ir, 32'h014A4822);
        check("t1_irpc0", ir_pc, 32'h0);
        tick(); tick(); tick();
        check("t1_valid1", {31'b0, ir_valid}, 32'h1);
        check("t1_ir1", ir, 32'h21290001);
        check("t1_irpc1", ir_pc, 32'h4);
        tick();
        check("t1_count2", fetch_count, 32'h2);

        // 2: decode stalls for 10 cycles in HOLD
        ir_ready = 1'b0;
        tick(); tick();
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t2_valid", {31'b0, ir_valid}, 32'h1);
            check("t2_ir", ir, 32'h08000001);
            check("t2_irpc", ir_pc, 32'h8);
            check("t2_pc", pc, 32'h8);
            check("t2_count", fetch_count, 32'h2);
            check("t2_im_addr", {22'b0, im_addr}, 32'h2);
        end
        ir_ready = 1'b1;
        tick();
        check("t2_count3", fetch_count, 32'h3);

        // 3: redirect while the IM word is in flight
        tick();
        redirect = 1'b1; redirect_pc = 32'h8; ir_ready = 1'b0;
        tick();
        redirect = 1'b0;
        check("t3_valid_drop", {31'b0, ir_valid}, 32'h0);
        tick();
        check("t3_no_stale", {31'b0, ir_valid}, 32'h0);
        tick();
        check("t3_ir", ir, 32'h08000001);
        check("t3_irpc", ir_pc, 32'h8);

        // 4: accept and redirect in the same cycle
        ir_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h4;
        tick();
        redirect = 1'b0; ir_ready = 1'b0;
        check("t4_count", fetch_count, 32'h4);
        check("t4_pc", pc, 32'h4);
        tick(); tick();
        check("t4_irpc", ir_pc, 32'h4);

        // 5: misaligned redirect target, sticky error flag
        redirect = 1'b1; redirect_pc = 32'h6;
        tick();
        redirect = 1'b0;
        check("t5_pc", pc, 32'h4);
        check("t5_err", {31'b0, misalign_err}, 32'h1);
        ir_ready = 1'b1;
        repeat (6) tick();
        check("t5_err_sticky", {31'b0, misalign_err}, 32'h1);
        check("t5_count", fetch_count, 32'h6);

        // 6: last IM word, wrap of im_addr past 4 KB, then reset mid-HOLD
        ir_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'hFFC;
        tick();
        redirect = 1'b0;
        tick(); tick();
        check("t6_ir_top", ir, 32'hDEADBEEF);
        ir_ready = 1'b1;
        tick();
        ir_ready = 1'b0;
        check("t6_pc_wrap", pc, 32'h1000);
        check("t6_im_addr_wrap", {22'b0, im_addr}, 32'h0);
        tick(); tick();
        check("t6_ir_alias", ir, 32'h014A4822);
        check("t6_irpc_full", ir_pc, 32'h1000);
        rst = 1'b1; ir_ready = 1'b1;
        tick();
        check("t6_rst_valid", {31'b0, ir_valid}, 32'h0);
        check("t6_rst_err", {31'b0, misalign_err}, 32'h0);
        rst = 1'b0;
        tick(); tick();
        check("t6_restart_irpc", ir_pc, 32'h0);
        check("t6_restart_ir", ir, 32'h014A4822);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            ir_ready    = ($urandom_range(0, 1) == 1);
            redirect    = ($urandom_range(0, 9) == 0);
            redirect_pc = $urandom & 32'h0000_3FFF;
            if ($urandom_range(0, 3) != 0) redirect_pc[1:0] = 2'b00;
            rst         = ($urandom_range(0, 99) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
